sm_serial_comparator: RTL

- Sequential, bit-serial counterpart of the 16-bit cascaded comparators.
- Accepts one pair of sign-magnitude operands through a valid/ready handshake.
- Walks the magnitude bits LSB-first, one bit per clock, so that each more significant difference overrides earlier ones. This is the opposite cascade direction to the combinational chain.
- Applies sign-magnitude rules at the end and returns gt/lt/eq/ae through a valid/ready result handshake. Sits between an operand source and any consumer needing area-cheap comparisons.

---
 rtl/sm_serial_comparator.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sm_serial_comparator.sv
// Bit-serial sign-magnitude comparator: one magnitude bit per clock, LSB first, result via valid/ready.
// Latency WIDTH-1 cycles from accept to out_valid; in_ready only in IDLE, result held until out_ready.
module sm_serial_comparator #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic             ae,
  output logic             busy
);

  localparam int MW = WIDTH - 1;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [MW-1:0] a_sh, b_sh;
  logic          sa, sb;
  logic [CW-1:0] cnt;
  logic          mgt, mlt, meq, anz, bnz;

  logic ai, bi, last, accept, finish, release_res;
  logic mgt_nx, mlt_nx, meq_nx, any_nz;
  logic gt_nx, lt_nx;

  assign ai          = a_sh[0];
  assign bi          = b_sh[0];
  assign last        = (cnt == CW'(WIDTH - 2));
  assign accept      = (state == IDLE) && in_valid;
  assign finish      = (state == SHIFT) && last;
  assign release_res = (state == DONE) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A differing bit overrides whatever lower bits decided, so the final MSB difference wins.
  always_comb begin
    mgt_nx = (ai != bi) ? ai : mgt;
    mlt_nx = (ai != bi) ? bi : mlt;
    meq_nx = meq & (ai == bi);
    any_nz = anz | bnz | ai | bi;
    gt_nx  = 1'b0;
    lt_nx  = 1'b0;
    if (!any_nz) begin
      gt_nx = 1'b0;
      lt_nx = 1'b0;
    end else if (sa != sb) begin
      gt_nx = sb;
      lt_nx = sa;
    end else if (!sa) begin
      gt_nx = mgt_nx;
      lt_nx = mlt_nx;
    end else begin
      gt_nx = mlt_nx;
      lt_nx = mgt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      cnt       <= '0;
      mgt       <= 1'b0;
      mlt       <= 1'b0;
      meq       <= 1'b0;
      anz       <= 1'b0;
      bnz       <= 1'b0;
      out_valid <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      ae        <= 1'b0;
    end else begin
      if (accept) begin
        a_sh <= a[MW-1:0];
        b_sh <= b[MW-1:0];
        sa   <= a[WIDTH-1];
        sb   <= b[WIDTH-1];
        cnt  <= '0;
        mgt  <= 1'b0;
        mlt  <= 1'b0;
        meq  <= 1'b1;
        anz  <= 1'b0;
        bnz  <= 1'b0;
      end else if (state == SHIFT) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        mgt  <= mgt_nx;
        mlt  <= mlt_nx;
        meq  <= meq_nx;
        anz  <= anz | ai;
        bnz  <= bnz | bi;
        // Saturates on the last bit so a stray extra cycle can never start a second pass.
        if (!last) cnt <= cnt + CW'(1);
      end

      if (finish) begin
        out_valid <= 1'b1;
        gt        <= gt_nx;
        lt        <= lt_nx;
        ae        <= meq_nx;
        eq        <= meq_nx & (sa == sb);
      end else if (release_res) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
